fabric_ccff_loader: RTL and testbench

Configuration-chain writer for the fabric. It accepts the bitstream as words over a valid/ready stream and serialises them into the head of the tile configuration flip-flop chain, pulsing the chain shift enable once per bit. After the last bit it checks the chain tail and then raises `cfg_done`. It sits at the fabric top on the programming clock domain, upstream of the first tile's `ccff_head` and downstream of the last tile's `ccff_tail`.

---
 rtl/fabric_ccff_loader.sv | 110 +++++++++++
 tb/tb_fabric_ccff_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_ccff_loader.sv
// Configuration-chain writer: takes bitstream words over valid/ready and
// shifts them LSB first into the tile CCFF chain, then checks the chain tail.
module fabric_ccff_loader #(
    parameter int unsigned CHAIN_LEN = 256,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              chain_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_error
);
    localparam int unsigned NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int unsigned CW     = $clog2(CHAIN_LEN + 1);
    localparam int unsigned BW     = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] LEN_C  = CW'(CHAIN_LEN);
    localparam logic [CW-1:0] LAST_C = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] NW_C   = CW'(NWORDS);
    localparam logic [BW-1:0] WW_C   = BW'(WORD_W);
    localparam logic [BW-1:0] ONE_C  = BW'(1);

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] wbuf_q, wbuf_d;
    logic [BW-1:0]     bits_left_q, bits_left_d;
    logic [CW-1:0]     shift_cnt_q, shift_cnt_d;
    logic [CW-1:0]     words_acc_q, words_acc_d;
    logic              first_bit_q, first_bit_d;
    logic              shift, accept;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q     <= IDLE;
            wbuf_q      <= '0;
            bits_left_q <= '0;
            shift_cnt_q <= '0;
            words_acc_q <= '0;
            first_bit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wbuf_q      <= wbuf_d;
            bits_left_q <= bits_left_d;
            shift_cnt_q <= shift_cnt_d;
            words_acc_q <= words_acc_d;
            first_bit_q <= first_bit_d;
        end
    end

    always_comb begin
        shift          = (state_q == LOAD) && (bits_left_q != '0) && (shift_cnt_q < LEN_C);
        word_ready     = (state_q == LOAD) && (bits_left_q <= ONE_C) && (words_acc_q < NW_C);
        accept         = word_ready && word_valid;
        chain_shift_en = shift;
        ccff_head      = shift && wbuf_q[0];
        busy           = (state_q == LOAD) || (state_q == CHECK);
        cfg_done       = (state_q == DONE);
        cfg_error      = (state_q == ERR);

        state_d     = state_q;
        wbuf_d      = wbuf_q;
        bits_left_d = bits_left_q;
        shift_cnt_d = shift_cnt_q;
        words_acc_d = words_acc_q;
        first_bit_d = first_bit_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d     = LOAD;
                    wbuf_d      = '0;
                    bits_left_d = '0;
                    shift_cnt_d = '0;
                    words_acc_d = '0;
                end
            end
            LOAD: begin
                if (shift) begin
                    wbuf_d      = wbuf_q >> 1;
                    bits_left_d = bits_left_q - 1'b1;
                    shift_cnt_d = shift_cnt_q + 1'b1;
                    if (shift_cnt_q == '0) begin
                        first_bit_d = wbuf_q[0];
                    end
                end
                // A reload on the last bit's edge overrides the decrement: no bubble.
                if (accept) begin
                    wbuf_d      = word_in;
                    bits_left_d = WW_C;
                    words_acc_d = words_acc_q + 1'b1;
                end
                if (shift && (shift_cnt_q == LAST_C)) begin
                    state_d     = CHECK;
                    bits_left_d = '0;
                end
            end
            CHECK: begin
                state_d = (ccff_tail == first_bit_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fabric_ccff_loader.sv
// Scoreboard bench: drivers push expected head bits and pass results, monitors
// pop and compare on every chain shift and on every pass completion.
module tb_fabric_ccff_loader;
    localparam int W   = 8;
    localparam int LA  = 16;
    localparam int LB  = 13;
    localparam int NWA = 2;
    localparam int NWB = 2;

    logic prog_clk = 1'b0;
    logic rst_n    = 1'b0;
    always #5 prog_clk = ~prog_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge prog_clk) cyc <= cyc + 1;

    logic         a_start = 1'b0, a_valid = 1'b0;
    logic [W-1:0] a_word  = '0;
    logic         a_ready, a_head, a_sh, a_tail, a_busy, a_done, a_err;
    logic         b_start = 1'b0, b_valid = 1'b0;
    logic [W-1:0] b_word  = '0;
    logic         b_ready, b_head, b_sh, b_tail, b_busy, b_done, b_err;

    logic [16:0]   chain_a   = '0;
    logic [LB-1:0] chain_b   = '0;
    logic          tail17    = 1'b0;
    logic          chain_clr = 1'b0;
    assign a_tail = tail17 ? chain_a[16] : chain_a[15];
    assign b_tail = chain_b[LB-1];

    always @(posedge prog_clk) begin
        if (chain_clr) chain_a <= '0;
        else if (a_sh) chain_a <= {chain_a[15:0], a_head};
        if (b_sh) chain_b <= {chain_b[LB-2:0], b_head};
    end

    fabric_ccff_loader #(.CHAIN_LEN(LA), .WORD_W(W)) u_dut_a (
        .prog_clk(prog_clk), .prog_reset_n(rst_n), .start(a_start),
        .word_in(a_word), .word_valid(a_valid), .word_ready(a_ready),
        .ccff_head(a_head), .chain_shift_en(a_sh), .ccff_tail(a_tail),
        .busy(a_busy), .cfg_done(a_done), .cfg_error(a_err)
    );

    fabric_ccff_loader #(.CHAIN_LEN(LB), .WORD_W(W)) u_dut_b (
        .prog_clk(prog_clk), .prog_reset_n(rst_n), .start(b_start),
        .word_in(b_word), .word_valid(b_valid), .word_ready(b_ready),
        .ccff_head(b_head), .chain_shift_en(b_sh), .ccff_tail(b_tail),
        .busy(b_busy), .cfg_done(b_done), .cfg_error(b_err)
    );

    bit       expa_bits[$];
    bit [1:0] expa_res[$];
    bit       expb_bits[$];
    bit [1:0] expb_res[$];
    int a_pulses, a_first, a_last, a_acc, a_e0, a_gap;
    int b_pulses, b_acc;
    logic a_fin_prev = 1'b0, b_fin_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event or timeout, expected clean handshake", name);
    endtask

    initial forever begin
        @(negedge prog_clk);
        if (!rst_n) begin
            a_fin_prev = 1'b0;
        end else begin
            if (a_sh) begin
                if (expa_bits.size() == 0) fail("a_extra_shift");
                else chk("a_head", int'(a_head), int'(expa_bits.pop_front()));
                if (a_pulses == 0) a_first = cyc + 1;
                a_last = cyc + 1;
                a_pulses++;
            end
            if (a_ready) chk("a_ready_limit", int'(a_acc < NWA), 1);
            if (a_ready && a_valid) a_acc++;
            if ((a_done || a_err) && !a_fin_prev) begin
                if (expa_res.size() == 0) fail("a_unexpected_end");
                else chk("a_result", int'({a_done, a_err}), int'(expa_res.pop_front()));
                chk("a_pulses", a_pulses, LA);
                chk("a_first_edge", a_first, a_e0 + 2 + a_gap);
                chk("a_last_edge", a_last, a_first + LA - 1 + a_gap);
                chk("a_done_edge", cyc, a_last + 1);
            end
            a_fin_prev = a_done || a_err;
        end
    end

    initial forever begin
        @(negedge prog_clk);
        if (!rst_n) begin
            b_fin_prev = 1'b0;
        end else begin
            if (b_sh) begin
                if (expb_bits.size() == 0) fail("b_extra_shift");
                else chk("b_head", int'(b_head), int'(expb_bits.pop_front()));
                b_pulses++;
            end
            if (b_ready) chk("b_ready_limit", int'(b_acc < NWB), 1);
            if (b_ready && b_valid) b_acc++;
            if ((b_done || b_err) && !b_fin_prev) begin
                if (expb_res.size() == 0) fail("b_unexpected_end");
                else chk("b_result", int'({b_done, b_err}), int'(expb_res.pop_front()));
                chk("b_pulses", b_pulses, LB);
            end
            b_fin_prev = b_done || b_err;
        end
    end

    task automatic send_a(input logic [W-1:0] w, input int gap);
        int t;
        if (gap > 0) begin
            a_valid = 1'b0;
            t = 0;
            while (!a_ready && t < 200) begin @(posedge prog_clk); #1; t++; end
            repeat (gap) begin @(posedge prog_clk); #1; end
        end
        a_valid = 1'b1;
        a_word  = w;
        t = 0;
        forever begin
            @(negedge prog_clk);
            if (a_ready) begin @(posedge prog_clk); #1; break; end
            t++;
            if (t > 200) begin fail("a_accept_timeout"); break; end
        end
        a_valid = 1'b0;
    endtask

    task automatic start_a();
        a_start = 1'b1;
        a_e0    = cyc + 1;
        @(posedge prog_clk); #1;
        a_start = 1'b0;
        chk("a_after_start", int'({a_busy, a_ready, a_done, a_err}), 'hC);
    endtask

    task automatic push_a(input logic [W-1:0] w0, input logic [W-1:0] w1, input bit err17,
                          output logic [LA-1:0] ec);
        logic [W-1:0] ws[2];
        ws[0] = w0;
        ws[1] = w1;
        for (int i = 0; i < LA; i++) begin
            expa_bits.push_back(ws[i/W][i%W]);
            ec[LA-1-i] = ws[i/W][i%W];
        end
        // With a zeroed 17-flop chain the tail at check time is 0.
        expa_res.push_back((err17 && w0[0]) ? 2'b01 : 2'b10);
        a_pulses = 0;
        a_acc    = 0;
    endtask

    task automatic pass_a(input logic [W-1:0] w0, input logic [W-1:0] w1, input int gap,
                          input bit err17, input bit mid_start);
        logic [LA-1:0] ec;
        int t;
        tail17 = err17;
        if (err17) begin
            chain_clr = 1'b1;
            @(posedge prog_clk); #1;
            chain_clr = 1'b0;
        end
        push_a(w0, w1, err17, ec);
        a_gap = gap;
        start_a();
        send_a(w0, gap);
        if (mid_start) begin
            a_start = 1'b1;
            @(posedge prog_clk); #1;
            a_start = 1'b0;
        end
        send_a(w1, gap);
        t = 0;
        while (expa_res.size() != 0 && t < 300) begin @(posedge prog_clk); #1; t++; end
        if (t >= 300) fail("a_pass_timeout");
        chk("a_chain", int'(chain_a[15:0]), int'(ec));
    endtask

    task automatic reset_mid_a();
        logic [LA-1:0] ec;
        int t;
        tail17 = 1'b0;
        push_a(8'hA5, 8'h3C, 1'b0, ec);
        a_gap = 0;
        start_a();
        a_valid = 1'b1;
        a_word  = 8'hA5;
        t = 0;
        while (a_pulses < 5 && t < 50) begin @(posedge prog_clk); #1; t++; end
        if (t >= 50) fail("a_reset_wait");
        #2 rst_n = 1'b0;
        #1;
        chk("a_reset_outputs", int'({a_ready, a_head, a_sh, a_busy, a_done, a_err}), 0);
        a_valid = 1'b0;
        expa_bits.delete();
        expa_res.delete();
        @(posedge prog_clk); #1;
        rst_n = 1'b1;
        @(posedge prog_clk); #1;
    endtask

    task automatic pass_b(input logic [W-1:0] w0, input logic [W-1:0] w1);
        logic [W-1:0]  ws[2];
        logic [LB-1:0] ec;
        int t;
        ws[0] = w0;
        ws[1] = w1;
        for (int i = 0; i < LB; i++) begin
            expb_bits.push_back(ws[i/W][i%W]);
            ec[LB-1-i] = ws[i/W][i%W];
        end
        expb_res.push_back(2'b10);
        b_pulses = 0;
        b_acc    = 0;
        b_start  = 1'b1;
        @(posedge prog_clk); #1;
        b_start = 1'b0;
        chk("b_after_start", int'({b_busy, b_ready, b_done, b_err}), 'hC);
        for (int k = 0; k < 2; k++) begin
            b_word  = ws[k];
            b_valid = 1'b1;
            t = 0;
            do begin @(negedge prog_clk); t++; end while (!b_ready && t < 100);
            @(posedge prog_clk); #1;
            if (t >= 100) fail("b_accept_timeout");
        end
        b_valid = 1'b0;
        t = 0;
        while (expb_res.size() != 0 && t < 300) begin @(posedge prog_clk); #1; t++; end
        if (t >= 300) fail("b_pass_timeout");
        chk("b_chain", int'(chain_b), int'(ec));
    endtask

    initial begin
        #1;
        chk("a_reset_state", int'({a_ready, a_head, a_sh, a_busy, a_done, a_err}), 0);
        chk("b_reset_state", int'({b_ready, b_head, b_sh, b_busy, b_done, b_err}), 0);
        repeat (3) @(posedge prog_clk);
        #1 rst_n = 1'b1;
        @(posedge prog_clk); #1;

        pass_a(8'hA5, 8'h3C, 0, 1'b0, 1'b0);
        pass_a(8'hA5, 8'h3C, 3, 1'b0, 1'b0);
        pass_a(8'h01, 8'h00, 0, 1'b1, 1'b0);
        reset_mid_a();
        pass_a(8'hA5, 8'h3C, 0, 1'b0, 1'b0);
        pass_a(8'h5A, 8'hC3, 0, 1'b0, 1'b1);
        for (int n = 0; n < 10; n++) begin
            pass_a(W'($urandom), W'($urandom),
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
        end

        pass_b(8'hFF, 8'h1F);
        for (int n = 0; n < 4; n++) begin
            pass_b(W'($urandom), W'($urandom));
        end

        repeat (3) @(posedge prog_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
